id_hazard_ctl: RTL and testbench

Interlock controller for the ID stage. A shift-register scoreboard tracks the destination registers of instructions issued from ID that have not yet been written back, and asserts `stall` whenever the instruction in ID reads one of them. `stall` holds IF and makes the ID latch emit a NOP. A two-state FSM serializes `syscall`: it stalls until the pipeline is fully drained. The block also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/id_hazard_ctl.sv | 105 ++++++++++
 tb/tb_id_hazard_ctl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctl.sv
// ID-stage interlock: shift-register scoreboard of in-flight destination
// registers, RAW/syscall stall generation and a saturating stall counter.
// Ports: clk_i/clr_i (sync active-high clear); ID-stage inputs (id_valid_i,
//   read{1,2}_num_i/_en_i, dest_en_i/dest_num_i, is_syscall_i, flush_i);
//   outputs stall_o, busy_o, drain_o, stall_count_o[31:0].
module id_hazard_ctl #(
  parameter int DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        id_valid_i,
  input  logic [4:0]  read1_num_i,
  input  logic [4:0]  read2_num_i,
  input  logic        read1_en_i,
  input  logic        read2_en_i,
  input  logic        dest_en_i,
  input  logic [4:0]  dest_num_i,
  input  logic        is_syscall_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        drain_o,
  output logic [31:0] stall_count_o
);

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

  state_e            state_q;
  logic [DEPTH-1:0]  slot_v_q, slot_v_d;
  logic [4:0]        slot_num_q [DEPTH];
  logic [4:0]        slot_num_d [DEPTH];
  logic [31:0]       stall_count_q, stall_count_d;

  logic hit1, hit2, raw, sys_wait, issue;

  assign busy_o  = |slot_v_q;
  assign drain_o = (state_q == ST_DRAIN);

  // Register 0 is hardwired, so reads of it never depend on an in-flight write.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_v_q[i] && (slot_num_q[i] == read1_num_i)) hit1 = 1'b1;
      if (slot_v_q[i] && (slot_num_q[i] == read2_num_i)) hit2 = 1'b1;
    end
    hit1 = hit1 && read1_en_i && (read1_num_i != 5'd0);
    hit2 = hit2 && read2_en_i && (read2_num_i != 5'd0);
  end

  assign raw      = id_valid_i && (hit1 || hit2);
  // A syscall waits for every older write; this covers DRAIN as well since
  // DRAIN is only held while the scoreboard is non-empty.
  assign sys_wait = id_valid_i && is_syscall_i && busy_o;
  // flush and clr both override any hazard.
  assign stall_o  = !clr_i && !flush_i && (raw || sys_wait);
  assign issue    = id_valid_i && !stall_o && !flush_i;

  // Scoreboard shift: the oldest slot drops out in the cycle its write lands.
  always_comb begin
    slot_v_d   = slot_v_q;
    slot_num_d = slot_num_q;
    for (int i = DEPTH - 1; i > 0; i--) begin
      slot_v_d[i]   = slot_v_q[i-1];
      slot_num_d[i] = slot_num_q[i-1];
    end
    slot_v_d[0]   = issue && dest_en_i && (dest_num_i != 5'd0);
    slot_num_d[0] = dest_num_i;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_o && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      slot_v_q      <= '0;
      stall_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_num_q[i] <= 5'd0;
    end else begin
      slot_v_q      <= slot_v_d;
      slot_num_q    <= slot_num_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Syscall serializer. A flushed syscall abandons the drain.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (id_valid_i && is_syscall_i && busy_o && !flush_i) state_q <= ST_DRAIN;
        ST_DRAIN: if (!busy_o || flush_i) state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_id_hazard_ctl.sv
module tb_id_hazard_ctl;

  logic        clk_i = 1'b0;
  logic        clr_i;
  logic        id_valid_i;
  logic [4:0]  read1_num_i, read2_num_i;
  logic        read1_en_i, read2_en_i;
  logic        dest_en_i;
  logic [4:0]  dest_num_i;
  logic        is_syscall_i;
  logic        flush_i;
  logic        stall_o, busy_o, drain_o;
  logic [31:0] stall_count_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = 32'd0;

  id_hazard_ctl #(.DEPTH(3)) dut (
    .clk_i(clk_i), .clr_i(clr_i), .id_valid_i(id_valid_i),
    .read1_num_i(read1_num_i), .read2_num_i(read2_num_i),
    .read1_en_i(read1_en_i), .read2_en_i(read2_en_i),
    .dest_en_i(dest_en_i), .dest_num_i(dest_num_i),
    .is_syscall_i(is_syscall_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .drain_o(drain_o),
    .stall_count_o(stall_count_o)
  );

  always #5 clk_i = ~clk_i;

  // One ID-stage cycle: inputs change just after the rising edge, and the
  // caller samples outputs 1 time unit later, well before the next edge.
  task automatic cyc(input logic cl, input logic v,
                     input logic [4:0] r1, input logic r1e,
                     input logic [4:0] r2, input logic r2e,
                     input logic de, input logic [4:0] dn,
                     input logic sys, input logic fl);
    @(posedge clk_i);
    #1;
    clr_i = cl; id_valid_i = v;
    read1_num_i = r1; read1_en_i = r1e;
    read2_num_i = r2; read2_en_i = r2e;
    dest_en_i = de; dest_num_i = dn;
    is_syscall_i = sys; flush_i = fl;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    // Clear held while a syscall-like, hazard-like ID word is present.
    cyc(1'b1, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (drain_o !== 1'b0) begin n_bad++; $display("FAIL reset_drain got %b want 0", drain_o); end
    n_cmp++; if (stall_count_o !== 32'd0) begin n_bad++; $display("FAIL reset_count got %h want 0", stall_count_o); end
    idle();
    exp_cnt = 32'd0;
  endtask

  task automatic test_independent();
    // addi $8, $1, imm  then  addi $9, $10, imm
    cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL indep_stall0 got %b want 0", stall_o); end
    cyc(1'b0, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL indep_stall1 got %b want 0", stall_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL indep_busy got %b want 1", busy_o); end
    repeat (4) idle();
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL indep_drained got %b want 0", busy_o); end
    n_cmp++; if (stall_count_o !== 32'd0) begin n_bad++; $display("FAIL indep_count got %h want 0", stall_count_o); end
  endtask

  // Producer writes $8; the dependent reaches ID k cycles later and stays
  // there while stalled. With DEPTH=3 it must stall at cycles k..3 after
  // the producer issued and issue at cycle 4 (or immediately when k>3).
  task automatic test_raw(input int k, input logic use_port2);
    logic exp_st;
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL raw_k%0d_producer got %b want 0", k, stall_o); end
    for (int j = 1; j < k; j++) idle();
    for (int j = k; j <= 4; j++) begin
      if (use_port2) cyc(1'b0, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      else           cyc(1'b0, 1'b1, 5'd8, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      exp_st = (j <= 3);
      if (exp_st) exp_cnt = exp_cnt + 32'd1;
      n_cmp++;
      if (stall_o !== exp_st) begin
        n_bad++; $display("FAIL raw_k%0d_stall cycle t+%0d got %b want %b", k, j, stall_o, exp_st);
      end
    end
    repeat (4) idle();
    n_cmp++; if (stall_count_o !== exp_cnt) begin n_bad++; $display("FAIL raw_k%0d_count got %0d want %0d", k, stall_count_o, exp_cnt); end
  endtask

  task automatic test_zero_and_disabled();
    // $0 destination never occupies a slot.
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL zero_dest_busy got %b want 0", busy_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL zero_read_stall got %b want 0", stall_o); end
    // Real write of $8, then matching numbers with the read ports disabled.
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd8, 1'b0, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL read_en0_stall got %b want 0", stall_o); end
    // Matching enabled read but ID holds a bubble.
    cyc(1'b0, 1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL bubble_stall got %b want 0", stall_o); end
    repeat (3) idle();
    n_cmp++; if (stall_count_o !== exp_cnt) begin n_bad++; $display("FAIL zero_count got %0d want %0d", stall_count_o, exp_cnt); end
  endtask

  task automatic test_syscall();
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL sys_stall_t1 got %b want 1", stall_o); end
    exp_cnt = exp_cnt + 32'd1;
    for (int j = 2; j <= 3; j++) begin
      cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      exp_cnt = exp_cnt + 32'd1;
      n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL sys_stall_t%0d got %b want 1", j, stall_o); end
      n_cmp++; if (drain_o !== 1'b1) begin n_bad++; $display("FAIL sys_drain_t%0d got %b want 1", j, drain_o); end
    end
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL sys_issue_t4 got %b want 0", stall_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL sys_busy_t4 got %b want 0", busy_o); end
    idle();
    n_cmp++; if (drain_o !== 1'b0) begin n_bad++; $display("FAIL sys_drain_exit got %b want 0", drain_o); end
    n_cmp++; if (stall_count_o !== exp_cnt) begin n_bad++; $display("FAIL sys_count got %0d want %0d", stall_count_o, exp_cnt); end
  endtask

  task automatic test_flush();
    // Flush during a RAW stall; the flushed word also carries a write of $9.
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL flush_pre_stall got %b want 1", stall_o); end
    exp_cnt = exp_cnt + 32'd1;
    cyc(1'b0, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1);
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b want 0", stall_o); end
    idle();
    idle();
    // Producer has retired; a slot from the flushed word would still be here.
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL flush_no_insert busy got %b want 0", busy_o); end
    n_cmp++; if (stall_count_o !== exp_cnt) begin n_bad++; $display("FAIL flush_count got %0d want %0d", stall_count_o, exp_cnt); end

    // Flush while draining for a syscall.
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    exp_cnt = exp_cnt + 32'd1;
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    n_cmp++; if (drain_o !== 1'b1) begin n_bad++; $display("FAIL flushdrain_in got %b want 1", drain_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL flushdrain_stall got %b want 0", stall_o); end
    idle();
    n_cmp++; if (drain_o !== 1'b0) begin n_bad++; $display("FAIL flushdrain_exit got %b want 0", drain_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL flushdrain_busy got %b want 1", busy_o); end
    repeat (2) idle();
    n_cmp++; if (stall_count_o !== exp_cnt) begin n_bad++; $display("FAIL flushdrain_count got %0d want %0d", stall_count_o, exp_cnt); end
  endtask

  task automatic test_clr_mid_drain();
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL clr_pre_stall got %b want 1", stall_o); end
    cyc(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    n_cmp++; if (drain_o !== 1'b1) begin n_bad++; $display("FAIL clr_in_drain got %b want 1", drain_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL clr_stall got %b want 0", stall_o); end
    idle();
    exp_cnt = 32'd0;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL clr_busy got %b want 0", busy_o); end
    n_cmp++; if (drain_o !== 1'b0) begin n_bad++; $display("FAIL clr_drain got %b want 0", drain_o); end
    n_cmp++; if (stall_count_o !== 32'd0) begin n_bad++; $display("FAIL clr_count got %h want 0", stall_count_o); end
  endtask

  task automatic test_saturate();
    idle();
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    n_cmp++; if (stall_count_o !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL sat_preload got %h want fffffffe", stall_count_o); end
    // Three stall cycles then issue; count reaches all-ones and holds.
    for (int j = 1; j <= 4; j++) begin
      cyc(1'b0, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      if (j >= 2) begin
        n_cmp++; if (stall_count_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_t%0d got %h want ffffffff", j, stall_count_o); end
      end
    end
    idle();
    n_cmp++; if (stall_count_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_hold got %h want ffffffff", stall_count_o); end
  endtask

  initial begin
    clr_i = 1'b1; id_valid_i = 1'b0;
    read1_num_i = 5'd0; read2_num_i = 5'd0; read1_en_i = 1'b0; read2_en_i = 1'b0;
    dest_en_i = 1'b0; dest_num_i = 5'd0; is_syscall_i = 1'b0; flush_i = 1'b0;
    test_reset();
    test_independent();
    test_raw(1, 1'b0);
    test_raw(2, 1'b1);
    test_raw(3, 1'b0);
    test_raw(4, 1'b1);
    test_zero_and_disabled();
    test_syscall();
    test_flush();
    test_clr_mid_drain();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
